// File: rtl/led_display_ctrl.sv
// ---------------------------------------------------------------------------
// led_display_ctrl
//
// LED output stage. A binary value is captured on a load strobe and shown on
// a bank of LEDs in one of four display modes:
//   00 direct            - LEDs follow the held value
//   01 blink             - held value during the "on" half-period, dark otherwise
//   10 bar graph         - the lowest min(hold, WIDTH) LEDs lit
//   11 change-highlight  - bits that changed on the last load blink,
//                          all other bits follow the held value
//
// Optional feature macro: LED_PWM_EN
//   Defined   : a free-running PWM_BITS counter gates the LEDs with a
//               global brightness duty cycle.
//   Undefined : no PWM counter, brightness is unused, LEDs are never gated.
//
// Parameters:
//   WIDTH     number of LEDs / width of value
//   BLINK_DIV clock cycles per blink half-period (>= 2)
//   PWM_BITS  width of brightness and of the PWM counter
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   value        value to display
//   value_valid  load strobe, value captured on any edge where it is 1
//   mode         display mode select
//   brightness   PWM duty control (LED_PWM_EN builds only)
//   leds         registered LED drive, 1 = lit
// ---------------------------------------------------------------------------
module led_display_ctrl #(
  parameter int WIDTH     = 16,
  parameter int BLINK_DIV = 12_500_000,
  parameter int PWM_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    value,
  input  logic                value_valid,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [WIDTH-1:0]    leds
);

  localparam int BCNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_DIV - 1);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_BAR    = 2'b10;
  localparam logic [1:0] MODE_CHANGE = 2'b11;

  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]  chg_q, chg_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [WIDTH-1:0]  leds_q, leds_d;

  logic              blink_wrap;
  logic [WIDTH-1:0]  bar_pat;
  logic [WIDTH-1:0]  pat;
  logic              pwm_on;

  // -------------------------------------------------------------------------
  // Held value and change mask. chg only ever compares the last two loads,
  // so an identical reload clears it.
  // -------------------------------------------------------------------------
  always_comb begin
    hold_d = hold_q;
    chg_d  = chg_q;
    if (value_valid) begin
      hold_d = value;
      chg_d  = hold_q ^ value;
    end
  end

  // -------------------------------------------------------------------------
  // Blink divider. Free-running in every mode; loads and mode changes never
  // disturb it, so blinking stays in step across mode switches.
  // -------------------------------------------------------------------------
  assign blink_wrap = (bcnt_q == BLINK_LAST);

  always_comb begin
    bcnt_d  = blink_wrap ? '0 : bcnt_q + BCNT_W'(1);
    phase_d = phase_q ^ blink_wrap;
  end

  // -------------------------------------------------------------------------
  // Bar graph: LED i lit when i < hold. Comparing hold against each index
  // directly also covers hold >= WIDTH (all lit) without a clamp.
  // -------------------------------------------------------------------------
  always_comb begin
    bar_pat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bar_pat[i] = (hold_q > WIDTH'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Display pattern
  // -------------------------------------------------------------------------
  always_comb begin
    pat = '0;
    unique case (mode)
      MODE_DIRECT: pat = hold_q;
      MODE_BLINK:  pat = phase_q ? '0 : hold_q;
      MODE_BAR:    pat = bar_pat;
      MODE_CHANGE: pat = (chg_q & {WIDTH{~phase_q}}) | (~chg_q & hold_q);
      default:     pat = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Brightness gating
  // -------------------------------------------------------------------------
`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  // all-ones brightness is full on rather than (2^N-1)/2^N
  assign pwm_on    = (pwm_cnt_q < brightness) || (&brightness);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  logic unused_brightness;

  assign unused_brightness = ^brightness;
  assign pwm_on            = 1'b1;
`endif

  assign leds_d = pat & {WIDTH{pwm_on}};

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      chg_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      leds_q  <= '0;
    end else begin
      hold_q  <= hold_d;
      chg_q   <= chg_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      leds_q  <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
module tb_led_display_ctrl;

  localparam int WIDTH     = 16;
  localparam int BLINK_DIV = 4;
  localparam int PWM_BITS  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [WIDTH-1:0]    value;
  logic                value_valid;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] brightness;
  logic [WIDTH-1:0]    leds;

  int total = 0;
  int bad   = 0;
  int k     = 0;   // edges since the last reset release

  led_display_ctrl #(
    .WIDTH     (WIDTH),
    .BLINK_DIV (BLINK_DIV),
    .PWM_BITS  (PWM_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .mode        (mode),
    .brightness  (brightness),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (k=%0d): got %h expected %h", tag, k, got, exp);
    end
  endtask

  // one rising edge, then settle; inputs and samples change 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // load v on the next edge, then drop the strobe
  task automatic load(input logic [WIDTH-1:0] v);
    value       = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  // blink: leds after edge k reflect phase after edge k-1; phase flips every 4 edges
  function automatic logic blink_on(input int kk);
    return (((kk - 1) / BLINK_DIV) % 2) == 0;
  endfunction

  initial begin
    rst         = 1'b1;
    value       = 16'h1234;
    value_valid = 1'b1;
    mode        = 2'b00;
    brightness  = '1;

    // reset: strobe ignored, leds dark
    repeat (3) tick();
    chk("reset_leds", leds, 16'h0000);
    value_valid = 1'b0;
    tick();
    chk("reset_leds2", leds, 16'h0000);

    rst = 1'b0;
    k   = 0;

    // direct mode, two-register load latency
    load(16'hA5C3);                                  // edge 1 = E
    chk("direct_at_E", leds, 16'h0000);
    tick();                                          // edge 2 = E+1
    chk("direct_after_E1", leds, 16'hA5C3);

    // blink with hold = FFFF
    load(16'hFFFF);                                  // edge 3
    mode = 2'b01;
    for (int n = 0; n < 17; n++) begin               // edges 4..20
      tick();
      chk("blink", leds, blink_on(k) ? 16'hFFFF : 16'h0000);
    end

    // bar graph
    mode = 2'b10;
    load(16'd0);     tick(); chk("bar_0",    leds, 16'h0000);
    load(16'd1);     tick(); chk("bar_1",    leds, 16'h0001);
    load(16'd5);     tick(); chk("bar_5",    leds, 16'h001F);
    load(16'd15);    tick(); chk("bar_15",   leds, 16'h7FFF);
    load(16'd16);    tick(); chk("bar_16",   leds, 16'hFFFF);
    load(16'hFFFF);  tick(); chk("bar_ffff", leds, 16'hFFFF);

    // change highlight: chg = 00FF ^ 0F0F = 0FF0
    mode = 2'b11;
    load(16'h00FF);
    load(16'h0F0F);
    for (int n = 0; n < 9; n++) begin
      tick();
      chk("chg_hi", leds, blink_on(k) ? 16'h0FFF : 16'h000F);
    end
    load(16'h0F0F);
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("chg_reload", leds, 16'h0F0F);
    end

    // brightness in direct mode with hold = FFFF
    mode = 2'b00;
    load(16'hFFFF);
    for (int b = 0; b < 4; b++) begin
      brightness = PWM_BITS'(b);
      for (int n = 0; n < 8; n++) begin
        tick();
`ifdef LED_PWM_EN
        // pwm_cnt after edge k is k mod 4; leds use the count after edge k-1
        chk("pwm", leds,
            ((b == 3) || (((k - 1) % 4) < b)) ? 16'hFFFF : 16'h0000);
`else
        chk("no_pwm", leds, 16'hFFFF);
`endif
      end
    end
    brightness = '1;

    // reset mid-blink with the strobe high
    mode = 2'b01;
    load(16'hFFFF);
    repeat (2) tick();
    rst         = 1'b1;
    value       = 16'h1234;
    value_valid = 1'b1;
    tick();
    chk("rst_mid_leds", leds, 16'h0000);
    tick();
    chk("rst_mid_leds2", leds, 16'h0000);
    rst         = 1'b0;
    value_valid = 1'b0;
    mode        = 2'b00;
    k           = 0;
    tick();
    tick();
    chk("rst_hold_zero", leds, 16'h0000);

    // blink restarts from reset release: toggle on the 4th edge
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    mode = 2'b01;
    k    = 0;
    load(16'hFFFF);                                  // edge 1
    for (int n = 0; n < 8; n++) begin                // edges 2..9
      tick();
      chk("blink_restart", leds, blink_on(k) ? 16'hFFFF : 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
